// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/DIV results land in HI/LO after a fixed busy period; MTHI/MTLO write in a single cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  // op bit 0 clear selects the signed variants; bit 1 selects divide
  logic             is_signed;
  logic             is_div;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] prod;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits the signed product
  assign mul_a = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
  assign mul_b = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
  assign prod  = mul_a * mul_b;

  // Magnitude division; most-negative / -1 wraps back to most-negative with zero remainder
  assign a_neg       = is_signed & a_q[WIDTH-1];
  assign b_neg       = is_signed & b_q[WIDTH-1];
  assign a_mag       = a_neg ? -a_q : a_q;
  assign b_mag       = b_neg ? -b_q : b_q;
  assign div_by_zero = (b_q == '0);
  assign den         = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag       = a_mag / den;
  assign r_mag       = a_mag % den;
  assign quot        = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem         = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              op_d    = op;
              a_d     = srcA;
              b_d     = srcB;
              cnt_d   = 32'(MUL_LAT);
              state_d = StBusy;
            end
            OpDiv, OpDivu: begin
              op_d    = op;
              a_d     = srcA;
              b_d     = srcB;
              cnt_d   = 32'(DIV_LAT);
              state_d = StBusy;
            end
            OpMthi:  hi_d = srcA;
            OpMtlo:  lo_d = srcA;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (cnt_q == 32'd1) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (!is_div) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (!div_by_zero) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and HI/LO width (minimum 2).
REQ-002 The block SHALL have parameter MUL_LAT, default 5, giving multiply busy cycles (minimum 1).
REQ-003 The block SHALL have parameter DIV_LAT, default 10, giving divide busy cycles (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to execute op this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-008 The block SHALL have port srcA, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO data.
REQ-009 The block SHALL have port srcB, input, WIDTH bits: multiplier or divisor.
REQ-010 The block SHALL have port busy, output, 1 bit: a MULT/DIV operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking HI/LO update from MULT/DIV.
REQ-012 The block SHALL have port hi, output, WIDTH bits: current HI register.
REQ-013 The block SHALL have port lo, output, WIDTH bits: current LO register.

Function
REQ-014 Accept condition SHALL be start=1 and busy=0 at a rising edge; start with busy=1 SHALL be ignored with no state change.
REQ-015 On accepting MULT/MULTU/DIV/DIVU, srcA, srcB and op SHALL be latched; later input changes SHALL not affect the result.
REQ-016 After accepting at edge k, busy SHALL be 1 for exactly LAT cycles (edges k..k+LAT-1 sample busy=1), where LAT is MUL_LAT for multiplies and DIV_LAT for divides.
REQ-017 HI/LO SHALL update at edge k+LAT, and busy=0 SHALL hold from that edge onward.
REQ-018 done SHALL be 1 for exactly the cycle following edge k+LAT and 0 otherwise.
REQ-019 MULT SHALL form the signed 2*WIDTH product: HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-020 MULTU SHALL form the unsigned 2*WIDTH product, split the same way.
REQ-021 DIV SHALL produce a signed quotient truncated toward zero in LO and a remainder in HI carrying the sign of the dividend.
REQ-022 DIVU SHALL produce an unsigned quotient in LO and remainder in HI.
REQ-023 DIV of most-negative by -1 SHALL give LO = most-negative value and HI = 0.
REQ-024 Divide by zero (DIV or DIVU) SHALL run the full DIV_LAT busy period and pulse done, with HI and LO unchanged.
REQ-025 MTHI/MTLO accepted at edge k SHALL write srcA to hi/lo at that edge; busy and done SHALL stay 0.
REQ-026 MTHI/MTLO presented while busy=1 SHALL be ignored.
REQ-027 Reserved op codes SHALL have no effect on any state.
REQ-028 A new operation SHALL be acceptable in the same cycle that done=1 (back-to-back), with no bubble.
REQ-029 hi/lo SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-030 With reset=1 at a rising edge, busy, done, hi and lo SHALL be 0 and any in-flight operation SHALL be discarded with no later done pulse.
REQ-031 reset SHALL take priority over start on the same edge.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-032 MULT srcA=0xFFFFFFFF, srcB=2 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done one cycle.
REQ-033 MULTU srcA=0xFFFFFFFF, srcB=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-034 DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> busy=1 for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then DIVU x/0 -> hi/lo unchanged, done pulses after 10 cycles.
REQ-036 Start MULT, then on busy cycle 2 present MTHI 0x1234 and a second MULT -> both ignored; only the first result appears.
REQ-037 Start DIV, assert reset on busy cycle 3 -> next cycle busy=0, hi=lo=0, and done never pulses; then MTLO 0xABCD -> lo=0xABCD after one edge.
